// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: state encoding, instruction width and
// the instruction field layout that the decoder also relies on.
package instr_fetch_unit_pkg;

   localparam int INSTR_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      FULL  = 2'd2,
      FLUSH = 2'd3
   } fetch_state_t;

   // Field layout: opcode [31:29], reg_1 [28:24], reg_2 [23:19], funct [3:0].
   typedef struct packed {
      logic [2:0]  opcode;
      logic [4:0]  reg_1;
      logic [4:0]  reg_2;
      logic [14:0] rsvd;
      logic [3:0]  funct;
   } instr_fields_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory req/ack port, decoder valid/ready port and
// the redirect input. The master modport is the fetch unit's view.
interface instr_fetch_unit_if #(
   parameter int ADDR_W = 32
);

   logic                                      imem_req;
   logic [ADDR_W-1:0]                         imem_addr;
   logic [instr_fetch_unit_pkg::INSTR_W-1:0]  imem_rdata;
   logic                                      imem_ack;
   logic [instr_fetch_unit_pkg::INSTR_W-1:0]  instr;
   logic [ADDR_W-1:0]                         instr_pc;
   logic                                      instr_valid;
   logic                                      instr_ready;
   logic                                      redirect_en;
   logic [ADDR_W-1:0]                         redirect_pc;

   modport master (
      output imem_req, imem_addr, instr, instr_pc, instr_valid,
      input  imem_rdata, imem_ack, instr_ready, redirect_en, redirect_pc
   );

   modport slave (
      input  imem_req, imem_addr, instr, instr_pc, instr_valid,
      output imem_rdata, imem_ack, instr_ready, redirect_en, redirect_pc
   );

endinterface

// File: rtl/instr_fetch_unit_fetch_pc_reg.sv
// Program counter register with redirect load and post-fetch increment.
// A load always wins over an increment in the same cycle.
module instr_fetch_unit_fetch_pc_reg #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_pc,
   input  logic              inc_en,
   output logic [ADDR_W-1:0] pc
);

   logic [ADDR_W-1:0] pc_r;

   // PC update; the increment wraps naturally from all-ones to zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_r <= RESET_PC;
      end else if (load_en) begin
         pc_r <= load_pc;
      end else if (inc_en) begin
         pc_r <= pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
         pc_r <= pc_r;
      end
   end

   assign pc = pc_r;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one word read at a time to instruction memory
// and hands each instruction to decode; redirects discard any stale fetch.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
   input logic                clk,
   input logic                rst,
   instr_fetch_unit_if.master bus
);

   fetch_state_t          state_r;
   fetch_state_t          state_s;
   logic [ADDR_W-1:0]     addr_r;
   logic [ADDR_W-1:0]     addr_s;
   logic [ADDR_W-1:0]     instr_pc_r;
   logic [ADDR_W-1:0]     instr_pc_s;
   logic [ADDR_W-1:0]     pc_s;
   logic [INSTR_W-1:0]    instr_r;
   logic [INSTR_W-1:0]    instr_s;
   logic                  valid_r;
   logic                  valid_s;
   logic                  req_r;
   logic                  req_s;
   logic                  pc_load_s;
   logic                  pc_inc_s;

   instr_fetch_unit_fetch_pc_reg #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk     (clk),
      .rst     (rst),
      .load_en (pc_load_s),
      .load_pc (bus.redirect_pc),
      .inc_en  (pc_inc_s),
      .pc      (pc_s)
   );

   // Next-state and next-output decode; redirect has priority in every state
   always_comb begin
      state_s    = state_r;
      addr_s     = addr_r;
      instr_s    = instr_r;
      instr_pc_s = instr_pc_r;
      valid_s    = valid_r;
      pc_load_s  = 1'b0;
      pc_inc_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.redirect_en) begin
               pc_load_s = 1'b1;
               valid_s   = 1'b0;
               addr_s    = bus.redirect_pc;
            end else begin
               addr_s    = pc_s;
            end
            state_s = REQ;
         end
         REQ: begin
            if (bus.redirect_en) begin
               pc_load_s = 1'b1;
               valid_s   = 1'b0;
               // A live request cannot be withdrawn, so without an ack we wait it out in FLUSH.
               if (bus.imem_ack) begin
                  addr_s  = bus.redirect_pc;
                  state_s = REQ;
               end else begin
                  state_s = FLUSH;
               end
            end else if (bus.imem_ack) begin
               instr_s    = bus.imem_rdata;
               instr_pc_s = addr_r;
               valid_s    = 1'b1;
               pc_inc_s   = 1'b1;
               state_s    = FULL;
            end else begin
               state_s = REQ;
            end
         end
         FULL: begin
            if (bus.redirect_en) begin
               pc_load_s = 1'b1;
               valid_s   = 1'b0;
               addr_s    = bus.redirect_pc;
               state_s   = REQ;
            end else if (bus.instr_ready) begin
               valid_s = 1'b0;
               addr_s  = pc_s;
               state_s = REQ;
            end else begin
               state_s = FULL;
            end
         end
         FLUSH: begin
            if (bus.redirect_en) begin
               pc_load_s = 1'b1;
               valid_s   = 1'b0;
               if (bus.imem_ack) begin
                  addr_s  = bus.redirect_pc;
                  state_s = REQ;
               end else begin
                  state_s = FLUSH;
               end
            end else if (bus.imem_ack) begin
               addr_s  = pc_s;
               state_s = REQ;
            end else begin
               state_s = FLUSH;
            end
         end
         default: begin
            valid_s = 1'b0;
            state_s = IDLE;
         end
      endcase
      req_s = (state_s == REQ) || (state_s == FLUSH);
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         addr_r     <= RESET_PC;
         instr_r    <= {INSTR_W{1'b0}};
         instr_pc_r <= {ADDR_W{1'b0}};
         valid_r    <= 1'b0;
         req_r      <= 1'b0;
      end else begin
         state_r    <= state_s;
         addr_r     <= addr_s;
         instr_r    <= instr_s;
         instr_pc_r <= instr_pc_s;
         valid_r    <= valid_s;
         req_r      <= req_s;
      end
   end

   assign bus.imem_req    = req_r;
   assign bus.imem_addr   = addr_r;
   assign bus.instr       = instr_r;
   assign bus.instr_pc    = instr_pc_r;
   assign bus.instr_valid = valid_r;

endmodule
